sonar_ping_ctrl: RTL
====================

# sonar_ping_ctrl

Sequencer for one sonar ping on the Sonar-on-Chip receive chain. It drives the transducer burst and masks the ringdown with a blanking window. It then gates the PCM/amplifier/MAF datapath through its clock enable, watches the comparator output for the echo, and reports the time of flight as a cycle count with a valid flag and an IRQ pulse. It sits between the Wishbone-configured registers and the datapath's `ce`/comparator nets.

## Interface
Parameters:
- `CNT_W`, 24: width of the time-of-flight counter and all duration config inputs.
- `HALF_W`, 8: width of the transducer half-period config.

Ports:
- `clk`, in, 1: system clock (`wb_clk_i`).
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: pulse; launches a ping when idle.
- `abort`, in, 1: level; returns the block to IDLE.
- `cfg_tx_len`, in, CNT_W: burst length in cycles.
- `cfg_tx_half`, in, HALF_W: the transducer square wave toggles every `cfg_tx_half+1` cycles.
- `cfg_blank`, in, CNT_W: blanking length in cycles.
- `cfg_timeout`, in, CNT_W: maximum total ping length in cycles, counted from the first TX cycle.
- `echo_i`, in, 1: comparator output (MAF ≥ threshold).
- `tx_o`, out, 1: transducer drive.
- `ce_o`, out, 1: datapath clock enable.
- `maf_clr_o`, out, 1: one-cycle clear for the MAF and PCM registers.
- `busy_o`, out, 1: high while not IDLE.
- `tof_o`, out, CNT_W: result; holds its value until the next accepted start.
- `tof_valid_o`, out, 1: `tof_o` is valid.
- `timeout_o`, out, 1: the last ping ended without an echo.
- `irq_o`, out, 1: one-cycle completion pulse.

## Operation
- States: IDLE, TX, BLANK, LISTEN, DONE.
- Counter `cnt` runs from 0, starting at the first cycle after start is accepted.
- **IDLE:**
  - `start` moves the block to TX, clears `cnt`, `tof_valid_o` and `timeout_o`, and pulses `maf_clr_o`.
  - `start` is ignored in every other state.
- **TX:**
  - `tx_o` starts at 1 and toggles every `cfg_tx_half+1` cycles.
  - Leaves for BLANK when `cnt == cfg_tx_len-1`.
  - If `cfg_tx_len == 0`, the block goes directly from IDLE to BLANK and `tx_o` stays 0.
- **BLANK:**
  - `tx_o` is 0 and `echo_i` is ignored.
  - Lasts `cfg_blank` cycles. With `cfg_blank == 0`, the block goes directly to LISTEN.
- **LISTEN:**
  - `echo_i` is sampled every cycle. When an echo is detected: `tof_o` ← current `cnt`, then go to DONE.
  - Otherwise, when `cnt >= cfg_timeout-1`: `tof_o` ← all ones, `timeout_o` ← 1, then go to DONE.
  - If echo and timeout occur in the same cycle, the echo wins.
- **DONE** (one cycle): `irq_o` = 1, `tof_valid_o` ← 1, next state IDLE.
- `ce_o` = 1 in TX, BLANK and LISTEN; 0 in IDLE and DONE.
- `cnt` saturates at all ones and never wraps.
- `abort` in any state:
  - Next state IDLE; `tx_o` and `ce_o` go to 0.
  - No IRQ; `tof_valid_o` stays 0.
  - `abort` takes priority over `start`, echo and timeout.
- Config inputs are sampled live, so software must hold them stable while `busy_o` is high.

## Timing
- Reset values:
  - State IDLE, `cnt` 0.
  - `tx_o`, `ce_o`, `maf_clr_o`, `busy_o`, `tof_valid_o`, `timeout_o` and `irq_o` all 0.
  - `tof_o` 0.
- All outputs are registered.
- `start` at edge k gives: `maf_clr_o`, `busy_o`, `ce_o` and `tx_o` high from k+1.
- `maf_clr_o` is high only at k+1.
- An echo sampled high in LISTEN at `cnt = N` gives: `tof_o = N` and DONE in the next cycle; `irq_o` and `tof_valid_o` in that same cycle; `busy_o` low one cycle later.
- Asserting reset mid-ping drops every output to its reset value immediately (asynchronous).

## Configuration
- `SONAR_ECHO_DEBOUNCE_EN`:
  - Defined: an echo is detected only after `echo_i` has been high for 3 consecutive LISTEN cycles.
    - `tof_o` is the `cnt` of the first of those three cycles.
    - The debounce history clears on leaving LISTEN.
  - Undefined: a single high `echo_i` sample in LISTEN is a detection.

## Test plan
- Reset, then `tx_len=10`, `half=1`, `blank=20`, `timeout=1000`, `echo_i` high at `cnt=100` → `tof_o=100`, one `irq_o` pulse, `tof_valid_o=1`, `timeout_o=0`, and `tx_o` reads 1,1,0,0,1,1,0,0,1,1 over the burst.
- `echo_i` held high from `start` with `tx_len=4`, `blank=6` → echo ignored until LISTEN, so `tof_o=10`.
- No echo, `timeout=50` → `tof_o=0xFFFFFF`, `timeout_o=1`, IRQ at cycle 51 after start.
- `abort` at `cnt=30` during LISTEN → IDLE the next cycle, no IRQ, `ce_o=0`; a second `start` while busy has no effect.
- `tx_len=0`, `blank=0` → first active cycle is LISTEN, `tx_o` stays 0, and an echo at `cnt=0` gives `tof_o=0`.
- With `SONAR_ECHO_DEBOUNCE_EN`: a 2-cycle glitch at `cnt=40` is ignored; `echo_i` high from `cnt=60` for 3 cycles → `tof_o=60`.

Source files
------------

// File: rtl/sonar_ping_ctrl.sv
// sonar_ping_ctrl -- sequencer for one sonar ping.
//
// Drives the transducer burst, blanks the ringdown, then gates the receive
// datapath (ce_o) while it listens for an echo on the comparator net.
// The time of flight is reported as a cycle count, with a valid flag and an
// IRQ pulse.
//
// Optional feature macro: SONAR_ECHO_DEBOUNCE_EN
//   defined   : an echo needs echo_i high for 3 consecutive LISTEN cycles;
//               tof_o is the count of the first of the three.
//   undefined : a single high echo_i sample in LISTEN is a detection.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             pulse, launches a ping when idle
//   abort             level, returns to IDLE (beats start/echo/timeout)
//   cfg_tx_len        burst length in cycles
//   cfg_tx_half       tx_o toggles every cfg_tx_half+1 cycles
//   cfg_blank         blanking length in cycles
//   cfg_timeout       max ping length in cycles from the first active cycle
//   echo_i            comparator output
//   tx_o              transducer drive
//   ce_o              datapath clock enable
//   maf_clr_o         one-cycle clear for MAF/PCM registers
//   busy_o            high while not IDLE
//   tof_o             time of flight (all ones on timeout)
//   tof_valid_o       tof_o is valid
//   timeout_o         last ping ended without an echo
//   irq_o             one-cycle completion pulse
// All outputs are registered.
module sonar_ping_ctrl #(
   parameter int CNT_W  = 24,
   parameter int HALF_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [CNT_W-1:0]  cfg_tx_len,
   input  logic [HALF_W-1:0] cfg_tx_half,
   input  logic [CNT_W-1:0]  cfg_blank,
   input  logic [CNT_W-1:0]  cfg_timeout,
   input  logic              echo_i,
   output logic              tx_o,
   output logic              ce_o,
   output logic              maf_clr_o,
   output logic              busy_o,
   output logic [CNT_W-1:0]  tof_o,
   output logic              tof_valid_o,
   output logic              timeout_o,
   output logic              irq_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_TX,
      S_BLANK,
      S_LISTEN,
      S_DONE
   } state_t;

   state_t             state, state_nx;
   logic [CNT_W-1:0]   cnt, cnt_nx, cnt_inc;
   logic [HALF_W-1:0]  ph, ph_nx;
   logic               tx_nx, mclr_nx, tofv_nx, to_nx;
   logic [CNT_W-1:0]   tof_nx;

   // Comparisons are done one bit wider so that cfg values of 0 or
   // tx_len+blank overflowing CNT_W never wrap into a false match.
   logic [CNT_W:0]     cnt_p1;
   logic               tx_end, blank_end, to_hit;
   logic               echo_det;
   logic [CNT_W-1:0]   echo_cnt;

   assign cnt_p1    = {1'b0, cnt} + (CNT_W+1)'(1);
   assign tx_end    = (cnt_p1 == {1'b0, cfg_tx_len});
   assign blank_end = (cnt_p1 == ({1'b0, cfg_tx_len} + {1'b0, cfg_blank}));
   assign to_hit    = (cnt_p1 >= {1'b0, cfg_timeout});
   // Saturating increment: cnt sticks at all ones.
   assign cnt_inc   = (&cnt) ? cnt : cnt + CNT_W'(1);

`ifdef SONAR_ECHO_DEBOUNCE_EN
   // Last two echo_i samples taken in LISTEN; cleared in every other state,
   // so the history always starts empty on entering LISTEN.
   logic [1:0] hist;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist <= '0;
      end else if (state == S_LISTEN) begin
         hist <= {hist[0], echo_i};
      end else begin
         hist <= '0;
      end
   end

   assign echo_det = echo_i & hist[0] & hist[1];
   assign echo_cnt = cnt - CNT_W'(2);
`else
   assign echo_det = echo_i;
   assign echo_cnt = cnt;
`endif

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      ph_nx    = ph;
      tx_nx    = 1'b0;
      mclr_nx  = 1'b0;
      tof_nx   = tof_o;
      tofv_nx  = tof_valid_o;
      to_nx    = timeout_o;

      case (state)
         S_IDLE: begin
            if (start) begin
               cnt_nx  = '0;
               tofv_nx = 1'b0;
               to_nx   = 1'b0;
               mclr_nx = 1'b1;
               if (cfg_tx_len != '0)     state_nx = S_TX;
               else if (cfg_blank != '0) state_nx = S_BLANK;
               else                      state_nx = S_LISTEN;
            end
         end
         S_TX: begin
            cnt_nx = cnt_inc;
            if (tx_end) state_nx = (cfg_blank != '0) ? S_BLANK : S_LISTEN;
         end
         S_BLANK: begin
            cnt_nx = cnt_inc;
            if (blank_end) state_nx = S_LISTEN;
         end
         S_LISTEN: begin
            cnt_nx = cnt_inc;
            if (echo_det) begin
               tof_nx   = echo_cnt;
               tofv_nx  = 1'b1;
               state_nx = S_DONE;
            end else if (to_hit) begin
               tof_nx   = '1;
               to_nx    = 1'b1;
               tofv_nx  = 1'b1;
               state_nx = S_DONE;
            end
         end
         S_DONE: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase

      // Abort overrides everything decided above: no result, no clear.
      if (abort) begin
         state_nx = S_IDLE;
         cnt_nx   = cnt;
         mclr_nx  = 1'b0;
         tof_nx   = tof_o;
         tofv_nx  = tof_valid_o;
         to_nx    = timeout_o;
      end

      // Burst waveform: starts high on entering TX, toggles after
      // cfg_tx_half+1 cycles in each level.
      if (state_nx == S_TX) begin
         if (state == S_TX) begin
            if (ph == cfg_tx_half) begin
               tx_nx = ~tx_o;
               ph_nx = '0;
            end else begin
               tx_nx = tx_o;
               ph_nx = ph + HALF_W'(1);
            end
         end else begin
            tx_nx = 1'b1;
            ph_nx = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         cnt         <= '0;
         ph          <= '0;
         tx_o        <= 1'b0;
         ce_o        <= 1'b0;
         maf_clr_o   <= 1'b0;
         busy_o      <= 1'b0;
         tof_o       <= '0;
         tof_valid_o <= 1'b0;
         timeout_o   <= 1'b0;
         irq_o       <= 1'b0;
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         ph          <= ph_nx;
         tx_o        <= tx_nx;
         ce_o        <= (state_nx == S_TX) || (state_nx == S_BLANK) ||
                        (state_nx == S_LISTEN);
         maf_clr_o   <= mclr_nx;
         busy_o      <= (state_nx != S_IDLE);
         tof_o       <= tof_nx;
         tof_valid_o <= tofv_nx;
         timeout_o   <= to_nx;
         irq_o       <= (state_nx == S_DONE);
      end
   end

endmodule
